sia_txarb: RTL and testbench
============================

SIA_TXARB -- requirements
Module: sia_txarb

Interface
REQ-001 SHALL have parameter REQUESTERS, default 4: number of byte requesters, range 2..4.
REQ-002 SHALL have parameter SHIFT_REG_WIDTH, default 12: frame width written to the transmit queue.
REQ-003 SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1: sole clock. One clock; reset is asynchronous and active-low.
- reset_ni, in, 1: asynchronous, active-low reset.
- req_dat_i, in, 8*REQUESTERS: byte per requester; requester k uses bits [8k+7:8k].
- req_valid_i, in, REQUESTERS: requester k has a byte pending.
- req_lock_i, in, REQUESTERS: requester k requests back-to-back grants.
- req_ack_o, out, REQUESTERS: one-cycle pulse; the byte was written to the queue.
- cfg_parity_i, in, 2: 00 none, 01 even, 10 odd, 11 none.
- cfg_stop2_i, in, 1: two stop bits.
- txq_dat_o, out, SHIFT_REG_WIDTH: frame to the queue.
- txq_we_o, out, 1: queue write strobe.
- txq_not_full_i, in, 1: queue status from the transmit queue.
- txq_empty_i, in, 1: queue status from the transmit queue.
- txq_idle_i, in, 1: engine status from the transmit queue.
- bits_o, out, 5: frame length in bits, to the queue's bits_i.
- busy_o, out, 1: state is not IDLE.

Function
REQ-004 SHALL implement states IDLE, ISSUE and SETTLE.
REQ-005 In IDLE, when txq_not_full_i=1 and an eligible requester is valid, the block SHALL, on that edge:
- latch the grant index g;
- latch the frame built from req_dat_i[g];
- go to ISSUE.
REQ-006 In ISSUE, the block SHALL assert txq_we_o=1 and req_ack_o[g]=1 for exactly one cycle, then go to SETTLE.
REQ-007 SETTLE SHALL last one cycle with txq_we_o=0 so that not_full reflects the write, then return to IDLE; minimum spacing is 3 cycles per byte.
REQ-008 Eligibility with no lock active: round-robin search starting at pointer p; after a grant to g, p SHALL become (g+1) mod REQUESTERS.
REQ-009 If req_lock_i[g]=1 during ISSUE, lock SHALL be set to g.
REQ-010 While lock is set, only g is eligible, and others SHALL stall even if g is not valid.
REQ-011 Lock SHALL clear in IDLE when req_lock_i[g]=0.
REQ-012 Deasserting req_valid_i before grant SHALL withdraw the request with no write.
REQ-013 req_dat_i SHALL be ignored after grant: the latched frame is written.
REQ-014 Frame layout, bit 0 first:
- bit 0 = 0 (start);
- bits 8:1 = data, LSB first;
- if parity is enabled, bit 9 = parity (even: XOR of data; odd: its inverse);
- then 1 or 2 stop bits = 1;
- all remaining upper bits = 1.
REQ-015 bits_o SHALL equal 10 + parity_enabled + stop2, giving 10..12 and never exceeding SHIFT_REG_WIDTH.
REQ-016 cfg_parity_i and cfg_stop2_i SHALL be latched into the active configuration only when state=IDLE, txq_empty_i=1 and txq_idle_i=1; otherwise the previous configuration is held.
REQ-017 When config latch and grant coincide in the same cycle, the frame SHALL use the newly latched configuration.
REQ-018 txq_not_full_i=0 in IDLE SHALL hold the block in IDLE with no grant and no ack.
REQ-019 req_ack_o SHALL be one-hot or zero.
REQ-020 txq_we_o=1 SHALL occur only when txq_not_full_i was 1 at the grant edge.

Reset
REQ-021 On reset_ni=0, asynchronously, the block SHALL set:
- state IDLE, p=0, lock cleared;
- txq_we_o=0, req_ack_o=0, busy_o=0;
- txq_dat_o all ones;
- active configuration = no parity, 1 stop, so bits_o=10.
REQ-022 Reset asserted mid-ISSUE SHALL suppress the pending write and ack; no partial write occurs.
REQ-023 Release SHALL be synchronised externally; the first grant SHALL be possible on the second edge after release.

Structure
REQ-024 Package sia_pkg SHALL hold:
- parity encodings;
- state encoding;
- the minimum frame-length constant 10.
REQ-025 Frame assembly and parity SHALL be sub-module sia_framer (combinational: data, parity mode, stop2 -> frame, bits).
REQ-026 Arbitration, lock and FSM SHALL reside in sia_txarb.

Verification
REQ-027 After reset, requester 0 valid with 8'hB6, no parity, 1 stop, not_full=1:
- txq_we_o on cycle 2 with txq_dat_o=12'hF6C;
- ack0 the same cycle;
- bits_o=10.
REQ-028 All four valid continuously, no locks: ack order 0,1,2,3,0; each write 3 cycles apart.
REQ-029 Requester 2 holds lock with three bytes while 1 and 3 are valid: three consecutive acks to 2, then 3, then 1.
REQ-030 Parity change to even plus stop2 while txq_empty_i=0: no bits_o change until empty=1 and idle=1, then bits_o=12; data 8'h01 gives frame 12'hE02.
REQ-031 txq_not_full_i=0 for 20 cycles with requesters valid: no we, no ack; the first write occurs 2 cycles after not_full rises.
REQ-032 reset_ni pulsed low during ISSUE: no ack and no we, and outputs take REQ-021 values immediately.

Source files
------------

// File: rtl/sia_pkg.sv
// Shared encodings and constants for the sia transmit arbiter.
// Imported by the framer and the arbiter.
package sia_pkg;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_EVEN  = 2'b01,
    PAR_ODD   = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_SETTLE = 2'b10
  } state_e;

  localparam int unsigned FRAME_MIN_BITS = 10;

  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/sia_framer.sv
// Combinational UART-style frame builder: start, data LSB first,
// optional parity, stop bits, idle-high padding.
module sia_framer
  import sia_pkg::*;
#(
  parameter int unsigned W = 12
) (
  input  logic [7:0]   data,
  input  logic [1:0]   par_mode,
  input  logic         stop2,
  output logic [W-1:0] frame,
  output logic [4:0]   bits
);

  logic pe;

  always_comb begin
    pe       = parity_on(par_mode);
    frame    = '1;
    frame[0] = 1'b0;
    frame[8:1] = data;
    if (pe) begin
      frame[9] = (^data) ^ (par_mode == PAR_ODD);
    end
    bits = 5'(FRAME_MIN_BITS) + {4'b0, pe} + {4'b0, stop2};
  end

endmodule

// File: rtl/sia_txarb.sv
// Round-robin byte arbiter with sticky lock feeding a transmit queue.
// Three-state grant/issue/settle cycle, one frame per three clocks.
module sia_txarb
  import sia_pkg::*;
#(
  parameter int unsigned REQUESTERS      = 4,
  parameter int unsigned SHIFT_REG_WIDTH = 12
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [8*REQUESTERS-1:0]      req_dat_i,
  input  logic [REQUESTERS-1:0]        req_valid_i,
  input  logic [REQUESTERS-1:0]        req_lock_i,
  output logic [REQUESTERS-1:0]        req_ack_o,
  input  logic [1:0]                   cfg_parity_i,
  input  logic                         cfg_stop2_i,
  output logic [SHIFT_REG_WIDTH-1:0]   txq_dat_o,
  output logic                         txq_we_o,
  input  logic                         txq_not_full_i,
  input  logic                         txq_empty_i,
  input  logic                         txq_idle_i,
  output logic [4:0]                   bits_o,
  output logic                         busy_o
);

  localparam int unsigned IW = $clog2(REQUESTERS);

  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, gnt_q, lock_idx_q, gsel;
  logic          lock_q, lock_hold, found, grant_en, cfg_ld;
  logic [1:0]    par_q, par_d;
  logic          stop2_q, stop2_d;
  logic [7:0]    gdat;
  logic [4:0]    bits_q, fr_bits;
  logic [SHIFT_REG_WIDTH-1:0] frame_q, fr_frame;
  int            idx;

  // A held lock masks everyone else, even when its owner is idle
  always_comb begin
    lock_hold = lock_q && req_lock_i[lock_idx_q];
    found = 1'b0;
    gsel  = '0;
    idx   = 0;
    if (lock_hold) begin
      found = req_valid_i[lock_idx_q];
      gsel  = lock_idx_q;
    end else begin
      for (int k = 0; k < int'(REQUESTERS); k++) begin
        idx = (int'(ptr_q) + k) % int'(REQUESTERS);
        if (!found && req_valid_i[idx]) begin
          found = 1'b1;
          gsel  = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    gdat = '0;
    for (int k = 0; k < int'(REQUESTERS); k++) begin
      if (gsel == IW'(k)) gdat = req_dat_i[8*k +: 8];
    end
  end

  assign cfg_ld  = (state_q == ST_IDLE) && txq_empty_i && txq_idle_i;
  assign par_d   = cfg_ld ? cfg_parity_i : par_q;
  assign stop2_d = cfg_ld ? cfg_stop2_i : stop2_q;

  sia_framer #(.W(SHIFT_REG_WIDTH)) u_framer (
    .data     (gdat),
    .par_mode (par_d),
    .stop2    (stop2_d),
    .frame    (fr_frame),
    .bits     (fr_bits)
  );

  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (txq_not_full_i && found) begin
          state_d  = ST_ISSUE;
          grant_en = 1'b1;
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      frame_q    <= '1;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
      bits_q     <= 5'(FRAME_MIN_BITS);
    end else begin
      state_q <= state_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      bits_q  <= fr_bits;
      if (grant_en) begin
        gnt_q   <= gsel;
        frame_q <= fr_frame;
        ptr_q   <= (gsel == IW'(REQUESTERS - 1)) ? '0 : gsel + 1'b1;
      end
      if (state_q == ST_IDLE && lock_q && !req_lock_i[lock_idx_q]) begin
        lock_q <= 1'b0;
      end
      if (state_q == ST_ISSUE && req_lock_i[gnt_q]) begin
        lock_q     <= 1'b1;
        lock_idx_q <= gnt_q;
      end
    end
  end

  always_comb begin
    req_ack_o = '0;
    for (int k = 0; k < int'(REQUESTERS); k++) begin
      req_ack_o[k] = (state_q == ST_ISSUE) && (gnt_q == IW'(k));
    end
  end

  assign txq_we_o  = (state_q == ST_ISSUE);
  assign busy_o    = (state_q != ST_IDLE);
  assign txq_dat_o = frame_q;
  assign bits_o    = bits_q;

endmodule

// File: tb/tb_sia_txarb.sv
// Random and directed checks of sia_txarb against a frame-level model.
// Model tracks grant phase, pointer, lock and config as plain integers.
module tb_sia_txarb;

  localparam int R = 4;

  logic          clk_i = 1'b0;
  logic          reset_ni;
  logic [8*R-1:0] req_dat_i;
  logic [R-1:0]  req_valid_i, req_lock_i, req_ack_o;
  logic [1:0]    cfg_parity_i;
  logic          cfg_stop2_i;
  logic [11:0]   txq_dat_o;
  logic          txq_we_o, txq_not_full_i, txq_empty_i, txq_idle_i;
  logic [4:0]    bits_o;
  logic          busy_o;

  sia_txarb #(.REQUESTERS(R), .SHIFT_REG_WIDTH(12)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .req_dat_i      (req_dat_i),
    .req_valid_i    (req_valid_i),
    .req_lock_i     (req_lock_i),
    .req_ack_o      (req_ack_o),
    .cfg_parity_i   (cfg_parity_i),
    .cfg_stop2_i    (cfg_stop2_i),
    .txq_dat_o      (txq_dat_o),
    .txq_we_o       (txq_we_o),
    .txq_not_full_i (txq_not_full_i),
    .txq_empty_i    (txq_empty_i),
    .txq_idle_i     (txq_idle_i),
    .bits_o         (bits_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int m_cnt, m_p, m_g, m_li;
  bit m_lk, m_st2;
  logic [1:0]  m_par;
  logic [11:0] m_frame;

  int ack_log[$];
  int cyc_log[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] mkframe(input logic [7:0] d,
                                          input logic [1:0] par,
                                          input bit st2);
    bit q[$];
    logic [11:0] f;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (par == 2'b01 || par == 2'b10) q.push_back((^d) ^ (par == 2'b10));
    q.push_back(1'b1);
    if (st2) q.push_back(1'b1);
    f = '1;
    for (int i = 0; i < q.size(); i++) f[i] = q[i];
    return f;
  endfunction

  function automatic int mbits();
    return 10 + ((m_par == 2'b01 || m_par == 2'b10) ? 1 : 0) + (m_st2 ? 1 : 0);
  endfunction

  task automatic mreset();
    m_cnt = 0; m_p = 0; m_g = 0; m_li = 0; m_lk = 0;
    m_par = 2'b00; m_st2 = 0; m_frame = '1;
  endtask

  task automatic model_edge();
    int win;
    logic [7:0] d;
    case (m_cnt)
      0: begin
        if (txq_empty_i && txq_idle_i) begin
          m_par = cfg_parity_i;
          m_st2 = cfg_stop2_i;
        end
        if (m_lk && !req_lock_i[m_li]) m_lk = 0;
        win = -1;
        if (m_lk) begin
          if (req_valid_i[m_li]) win = m_li;
        end else begin
          for (int k = 0; k < R; k++)
            if (win < 0 && req_valid_i[(m_p + k) % R]) win = (m_p + k) % R;
        end
        if (txq_not_full_i && win >= 0) begin
          m_g = win;
          d = req_dat_i[8*win +: 8];
          m_frame = mkframe(d, m_par, m_st2);
          m_p = (win + 1) % R;
          m_cnt = 1;
        end
      end
      1: begin
        if (req_lock_i[m_g]) begin
          m_lk = 1;
          m_li = m_g;
        end
        m_cnt = 2;
      end
      default: m_cnt = 0;
    endcase
  endtask

  task automatic check_all();
    chk("we",   txq_we_o, (m_cnt == 1));
    chk("ack",  req_ack_o, (m_cnt == 1) ? (1 << m_g) : 0);
    chk("busy", busy_o, (m_cnt != 0));
    chk("bits", bits_o, mbits());
    chk("dat",  txq_dat_o, m_frame);
    if (req_ack_o != 0) begin
      for (int k = 0; k < R; k++)
        if (req_ack_o[k]) ack_log.push_back(k);
      cyc_log.push_back(cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    cyc++;
    if (reset_ni) model_edge();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic idle_inputs();
    req_valid_i = '0; req_lock_i = '0; req_dat_i = '0;
    cfg_parity_i = 2'b00; cfg_stop2_i = 1'b0;
    txq_not_full_i = 1'b1; txq_empty_i = 1'b1; txq_idle_i = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_ni = 1'b0;
    mreset();
    idle_inputs();
    #1;
    check_all();
    @(negedge clk_i);
    reset_ni = 1'b1;
    ack_log.delete();
    cyc_log.delete();
  endtask

  int cnt2, nwe, lat;
  bit hit;

  initial begin
    reset_ni = 1'b0;
    idle_inputs();
    mreset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_all();
    reset_ni = 1'b1;

    // Single byte after reset
    req_valid_i = 4'b0001;
    req_dat_i[7:0] = 8'hB6;
    step();
    chk("t27_we", txq_we_o, 1);
    chk("t27_ack", req_ack_o, 4'b0001);
    chk("t27_dat", txq_dat_o, 12'hF6C);
    chk("t27_bits", bits_o, 10);
    req_valid_i = '0;
    repeat (3) step();

    // Plain round robin
    do_reset();
    req_valid_i = 4'hF;
    req_dat_i = $urandom;
    repeat (16) step();
    req_valid_i = '0;
    repeat (3) step();
    chk("t28_cnt", ack_log.size() >= 5, 1);
    if (ack_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("t28_ord", ack_log[i], i % R);
      for (int i = 1; i < 5; i++)
        chk("t28_gap", cyc_log[i] - cyc_log[i-1], 3);
    end

    // Locked burst from requester 2
    do_reset();
    req_valid_i = 4'b0100;
    req_lock_i  = 4'b0100;
    req_dat_i   = $urandom;
    step();
    req_valid_i = 4'b1110;
    cnt2 = 0;
    if (req_ack_o[2]) cnt2++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_ack_o[2]) cnt2++;
      if (cnt2 >= 3) req_lock_i = '0;
    end
    req_valid_i = '0;
    repeat (3) step();
    chk("t29_cnt", ack_log.size() >= 5, 1);
    if (ack_log.size() >= 5) begin
      chk("t29_a0", ack_log[0], 2);
      chk("t29_a1", ack_log[1], 2);
      chk("t29_a2", ack_log[2], 2);
      chk("t29_a3", ack_log[3], 3);
      chk("t29_a4", ack_log[4], 1);
    end

    // Config held until queue drains
    do_reset();
    txq_empty_i = 1'b0;
    cfg_parity_i = 2'b01;
    cfg_stop2_i = 1'b1;
    repeat (4) step();
    chk("t30_hold", bits_o, 10);
    txq_empty_i = 1'b1;
    txq_idle_i  = 1'b0;
    repeat (2) step();
    chk("t30_hold2", bits_o, 10);
    txq_idle_i = 1'b1;
    step();
    chk("t30_bits", bits_o, 12);
    req_valid_i = 4'b0001;
    req_dat_i[7:0] = 8'h01;
    step();
    chk("t30_dat", txq_dat_o, 12'hE02);
    req_valid_i = '0;
    repeat (3) step();

    // Backpressure from the queue
    do_reset();
    txq_not_full_i = 1'b0;
    req_valid_i = 4'hF;
    req_dat_i = $urandom;
    nwe = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (txq_we_o || req_ack_o != 0) nwe++;
    end
    chk("t31_quiet", nwe, 0);
    txq_not_full_i = 1'b1;
    lat = 0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      lat++;
      if (txq_we_o) hit = 1;
    end
    chk("t31_lat", hit ? lat + 1 : 99, 2);
    req_valid_i = '0;
    repeat (3) step();

    // Reset landing on an issue cycle
    do_reset();
    req_valid_i = 4'b0010;
    req_dat_i = $urandom;
    step();
    chk("t32_pre", txq_we_o, 1);
    reset_ni = 1'b0;
    mreset();
    #1;
    chk("t32_we", txq_we_o, 0);
    chk("t32_ack", req_ack_o, 0);
    chk("t32_busy", busy_o, 0);
    chk("t32_dat", txq_dat_o, 12'hFFF);
    chk("t32_bits", bits_o, 10);
    @(negedge clk_i);
    check_all();
    reset_ni = 1'b1;
    req_valid_i = '0;
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      req_valid_i    = 4'($urandom);
      req_dat_i      = $urandom;
      req_lock_i     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      txq_not_full_i = ($urandom_range(0, 4) != 0);
      txq_empty_i    = ($urandom_range(0, 2) != 0);
      txq_idle_i     = ($urandom_range(0, 2) != 0);
      cfg_parity_i   = 2'($urandom);
      cfg_stop2_i    = 1'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
